// File: rtl/disp_bcd_feeder.sv
// Binary-to-BCD feeder and scan clock for the right-hand 7-seg driver.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module disp_bcd_feeder #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] number,
  output logic        ovf,
  output logic [3:0]  blank,
  output logic        scan_clk
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FIN
  } state_t;

  localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);

  state_t      state;
  logic [15:0] bin;
  logic [19:0] bcd;
  logic [19:0] bcd_adj;
  logic [4:0]  iter;
  logic [19:0] div;
  logic        ovf_nx;
  logic [15:0] num_nx;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign ovf_nx = |bcd[19:16];
  assign num_nx = ovf_nx ? 16'h9999 : bcd[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      bin    <= '0;
      bcd    <= '0;
      iter   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      number <= '0;
      ovf    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            bin   <= value;
            bcd   <= '0;
            iter  <= '0;
            busy  <= 1'b1;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {bcd, bin} <= {bcd_adj[18:0], bin, 1'b0};
          iter <= iter + 5'd1;
          if (iter == 5'd15)
            state <= S_FIN;
        end
        S_FIN: begin
          number <= num_nx;
          ovf    <= ovf_nx;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] blank_nx;
  logic [3:0] blank_q;

  // Blank a digit only when it and every more significant digit are zero.
  always_comb begin
    blank_nx = '0;
    if (!ovf_nx) begin
      blank_nx[3] = num_nx[15:12] == 4'd0;
      blank_nx[2] = blank_nx[3] && (num_nx[11:8] == 4'd0);
      blank_nx[1] = blank_nx[2] && (num_nx[7:4] == 4'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      blank_q <= '0;
    else if (state == S_FIN)
      blank_q <= blank_nx;
  end

  assign blank = blank_q;
`else
  assign blank = 4'b0000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div      <= '0;
      scan_clk <= 1'b0;
    end else if (div == DIV_LAST) begin
      div      <= '0;
      scan_clk <= ~scan_clk;
    end else begin
      div <= div + 20'd1;
    end
  end

endmodule
